// File: rtl/sap_ctrl_seq.sv
// rtl/sap_ctrl_seq.sv - SAP-1 controller-sequencer: T1..T6 ring counter and control-word decode
//
// Ports:
//   clk       system clock; ring and halted state advance on the falling edge
//   cls       asynchronous active-high clear (ring -> T1, halted -> 0)
//   prog_run  1 = run, 0 = programming mode (controls forced to 0, ring parks at T1)
//   opcode    instruction register upper nibble
//   ring      one-hot T-state (bit0 = T1)
//   cp, ep, mar_in, ram_out, li, ei, la, ea, su, eu, lb, lo, jmp
//             active-high control strobes for the datapath
//   hlt       halted flag
//
// Optional feature macro: SAP_JMP_EN (enables JMP decode; jmp is tied 0 otherwise).

module sap_ctrl_seq #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_JMP = 4'h3,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic       clk,
  input  logic       cls,
  input  logic       prog_run,
  input  logic [3:0] opcode,
  output logic [5:0] ring,
  output logic       cp,
  output logic       ep,
  output logic       mar_in,
  output logic       ram_out,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo,
  output logic       jmp,
  output logic       hlt
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  t_state_e state, state_next;
  logic     halted, halted_next;

  // Falling-edge state so the control word settles half a cycle before the
  // datapath registers sample it on the rising edge.
  always_ff @(negedge clk or posedge cls) begin
    if (cls) begin
      state  <= T1;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= halted_next;
    end
  end

  // Next-state logic. Once halted the ring is frozen; only cls recovers it.
  always_comb begin
    state_next  = state;
    halted_next = halted;
    if (!halted) begin
      if (!prog_run) begin
        state_next = T1;
      end else begin
        case (state)
          T1: state_next = T2;
          T2: state_next = T3;
          T3: begin
            state_next = T4;
            // HLT takes effect on the edge that enters T4
            if (opcode == OP_HLT) halted_next = 1'b1;
          end
          T4: state_next = T5;
          T5: state_next = T6;
          T6: state_next = T1;
          default: state_next = T1;
        endcase
      end
    end
  end

  // Control-word decode. Gating by cls keeps strobes low for the whole clear
  // pulse, independent of when the async reset reaches the state register.
  always_comb begin
    cp      = 1'b0;
    ep      = 1'b0;
    mar_in  = 1'b0;
    ram_out = 1'b0;
    li      = 1'b0;
    ei      = 1'b0;
    la      = 1'b0;
    ea      = 1'b0;
    su      = 1'b0;
    eu      = 1'b0;
    lb      = 1'b0;
    lo      = 1'b0;
    jmp     = 1'b0;
    if (!cls && prog_run && !halted) begin
      case (state)
        T1: begin ep = 1'b1; mar_in = 1'b1; end
        T2: cp = 1'b1;
        T3: begin ram_out = 1'b1; li = 1'b1; end
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            mar_in = 1'b1;
            ei     = 1'b1;
          end else if (opcode == OP_OUT) begin
            ea = 1'b1;
            lo = 1'b1;
          end
`ifdef SAP_JMP_EN
          else if (opcode == OP_JMP) begin
            ei  = 1'b1;
            jmp = 1'b1;
          end
`endif
        end
        T5: begin
          if (opcode == OP_LDA) begin
            ram_out = 1'b1;
            la      = 1'b1;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            ram_out = 1'b1;
            lb      = 1'b1;
          end
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            eu = 1'b1;
            la = 1'b1;
            su = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign ring = state;
  assign hlt  = halted;

endmodule

// File: doc/sap_ctrl_seq.md
Name: sap_ctrl_seq

Overview:
Controller-sequencer for the SAP-1 datapath. A 6-state ring counter (T1..T6) is combined with the 4-bit opcode from the instruction register to produce the control word. The control word drives the RAM/MAR stage (mar_in, ram_out), the PC, IR, accumulator, ALU, B and output registers. The block sits directly upstream of the RAM/MAR stage and supplies its load and bus-enable strobes.

Parameters:
OP_LDA, 4'h0, LDA opcode encoding
OP_ADD, 4'h1, ADD opcode encoding
OP_SUB, 4'h2, SUB opcode encoding
OP_JMP, 4'h3, JMP opcode encoding (used only with SAP_JMP_EN)
OP_OUT, 4'hE, OUT opcode encoding
OP_HLT, 4'hF, HLT opcode encoding

Ports:
clk  input  1  system clock; sequencer state advances on the falling edge
cls  input  1  asynchronous active-high reset/clear
prog_run  input  1  1 = run, 0 = programming mode
opcode  input  4  IR upper nibble
ring  output  6  one-hot T-state (bit0 = T1), drives LEDs
cp  output  1  PC increment
ep  output  1  PC drives BUS
mar_in  output  1  MAR load from BUS
ram_out  output  1  RAM drives BUS
li  output  1  IR load
ei  output  1  IR low nibble drives BUS
la  output  1  accumulator load
ea  output  1  accumulator drives BUS
su  output  1  ALU subtract select
eu  output  1  ALU drives BUS
lb  output  1  B register load
lo  output  1  output register load
jmp  output  1  PC parallel load (always 0 without SAP_JMP_EN)
hlt  output  1  halted flag

Behaviour:
- All control outputs are active-high. The control word is a combinational decode of (ring, opcode, prog_run, halted state).
- Ring and halted state update on negedge clk. Datapath registers latch on posedge, mid-T-state, so the control word is stable half a cycle before use.
- cls=1 (asynchronous): ring=6'b000001, hlt=0, and every control output is 0 while cls is held.
- Ring advances T1->T2->...->T6->T1 on each falling edge when prog_run=1, hlt=0 and cls=0.
- Fetch cycle (every opcode):
  - T1: ep, mar_in
  - T2: cp
  - T3: ram_out, li
- Execute, T4/T5/T6:
  - LDA: T4 mar_in+ei; T5 ram_out+la; T6 none
  - ADD: T4 mar_in+ei; T5 ram_out+lb; T6 eu+la
  - SUB: T4 mar_in+ei; T5 ram_out+lb; T6 eu+su+la
  - OUT: T4 ea+lo; T5 none; T6 none
  - HLT: at T4, hlt is set on the falling edge that enters T4. From then on the ring is frozen at T4 and all control outputs are 0. Only cls clears it.
  - Undefined opcodes: T4..T6 are NOPs with all outputs 0. The ring still cycles.
- At most one bus driver (ep, ram_out, ei, ea, eu) is asserted in any state.
- prog_run=0:
  - All control outputs are forced to 0 combinationally.
  - On the next falling edge the ring returns to T1 and holds there.
  - A drop in prog_run mid-instruction aborts that instruction. Returning to run restarts at T1 fetch.
  - hlt is unaffected by prog_run.
- cls asserted mid-instruction returns the block to T1 immediately (asynchronous). No partial control pulse is extended.

Optional Feature:
SAP_JMP_EN. When defined, opcode OP_JMP decodes T4 as ei+jmp, with T5 and T6 as none. When not defined, OP_JMP is treated as an undefined opcode (NOP), and the jmp port is tied to 0.

Test Plan:
- cls pulse mid-T3 -> ring=000001, hlt=0 and all controls 0 immediately, before any clock edge; fetch resumes at T1 after release.
- opcode=4'h0, prog_run=1, 6 falling edges -> ring sequence 01,02,04,08,10,20; controls: T1 ep+mar_in, T2 cp, T3 ram_out+li, T4 mar_in+ei, T5 ram_out+la, T6 all 0.
- opcode=4'h2 -> T6 has eu=1, su=1, la=1 and no other output; check opcode=4'h1 gives the same T6 with su=0.
- opcode=4'hF -> hlt=1 after the edge into T4; ring stays 001000 for 10 further edges with all controls 0; cls clears hlt.
- prog_run dropped at T5 -> controls go to 0 immediately; ring=000001 after the next falling edge and holds; raising prog_run gives T1 fetch on the next state.
- SAP_JMP_EN defined, opcode=4'h3 -> T4 ei=1, jmp=1; undefined: jmp=0 throughout. Undefined opcode 4'h7 -> T4..T6 all 0 and the ring keeps cycling.
